// File: rtl/micro_pkg.sv
// Shared types and constants for the microprogram sequencer and its microcode ROM.
package micro_pkg;

  localparam int UCTRL_W = 16;
  localparam int UWORD_W = UCTRL_W + 8;

  typedef enum logic [1:0] {
    SEQ_NEXT     = 2'b00,
    SEQ_END      = 2'b01,
    SEQ_JUMP     = 2'b10,
    SEQ_WAIT_MEM = 2'b11
  } seq_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    TRAP = 2'd2
  } state_e;

  typedef struct packed {
    logic [UCTRL_W-1:0] ctrl;
    seq_e               seq;
    logic [5:0]         target;
  } uword_t;

  localparam logic [5:0] ADDR_NOP     = 6'd0;
  localparam logic [5:0] ADDR_LOAD    = 6'd11;
  localparam logic [5:0] ADDR_STORE   = 6'd12;
  localparam logic [5:0] ADDR_ILLEGAL = 6'd63;

  function automatic uword_t mk_word(input logic [UCTRL_W-1:0] ctrl,
                                     input seq_e seq,
                                     input logic [5:0] target);
    uword_t w;
    w.ctrl   = ctrl;
    w.seq    = seq;
    w.target = target;
    return w;
  endfunction

endpackage

// File: rtl/micro_rom.sv
// 64-entry combinational microcode ROM indexed by the micro-PC.
// TEST_LOOP_EN places a JUMP-to-self routine at entry 30 for exercising the watchdog.
module micro_rom
  import micro_pkg::*;
#(
  parameter bit TEST_LOOP_EN = 1'b0
) (
  input  logic [5:0] addr,
  output uword_t     word
);

  always_comb begin
    word = mk_word('0, SEQ_END, 6'd0);
    case (addr)
      ADDR_LOAD:  word = mk_word(16'h2001, SEQ_JUMP, 6'd40);
      6'd40:      word = mk_word(16'h2002, SEQ_WAIT_MEM, 6'd0);
      6'd41:      word = mk_word(16'h2003, SEQ_END, 6'd0);
      ADDR_STORE: word = mk_word(16'h3001, SEQ_JUMP, 6'd44);
      6'd44:      word = mk_word(16'h3002, SEQ_WAIT_MEM, 6'd0);
      6'd45:      word = mk_word(16'h3003, SEQ_END, 6'd0);
      6'd30: begin
        if (TEST_LOOP_EN) word = mk_word(16'h4000, SEQ_JUMP, 6'd30);
      end
      default: begin
        // single-word routines; entry 0 (NOP) keeps ctrl=0
        if ((addr >= 6'd1 && addr <= 6'd10) || (addr >= 6'd13 && addr <= 6'd26))
          word = mk_word(16'h1000 | {10'd0, addr}, SEQ_END, 6'd0);
      end
    endcase
  end

endmodule

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: dispatches decode entry addresses and walks the microcode ROM.
// Define MICRO_ILLEGAL_TRAP_EN to trap on dispatch of address 63; otherwise it runs as a NOP.
module micro_sequencer
  import micro_pkg::*;
#(
  parameter int CTRL_W       = UCTRL_W,
  parameter int MAX_STEPS    = 15,
  parameter bit TEST_LOOP_EN = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [5:0]        mapped_address,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic              stall,
  input  logic              mem_done,
  output logic [CTRL_W-1:0] ctrl_word,
  output logic              ctrl_valid,
  output logic [5:0]        upc,
  output logic              trap,
  output logic              trap_cause,
  input  logic              trap_ack
);

  state_e     state_q, state_d;
  logic [5:0] upc_q, upc_d;
  logic [3:0] step_cnt_q, step_cnt_d;
  logic       trap_cause_q, trap_cause_d;
  uword_t     rom_word;
  logic       dispatch;
  logic       advance;
  logic       illegal_dispatch;

  micro_rom #(.TEST_LOOP_EN(TEST_LOOP_EN)) u_rom (
    .addr (upc_q),
    .word (rom_word)
  );

`ifdef MICRO_ILLEGAL_TRAP_EN
  assign illegal_dispatch = (mapped_address == ADDR_ILLEGAL);
`else
  assign illegal_dispatch = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    upc_d        = upc_q;
    step_cnt_d   = step_cnt_q;
    trap_cause_d = trap_cause_q;
    instr_ready  = 1'b0;
    ctrl_valid   = 1'b0;
    dispatch     = 1'b0;
    advance      = 1'b0;

    case (state_q)
      IDLE: begin
        instr_ready = 1'b1;
        dispatch    = instr_valid;
      end
      EXEC: begin
        if (!stall) begin
          case (rom_word.seq)
            SEQ_END: begin
              instr_ready = 1'b1;
              ctrl_valid  = 1'b1;
              if (instr_valid) dispatch = 1'b1;
              else             state_d  = IDLE;
            end
            SEQ_WAIT_MEM: begin
              if (mem_done) begin
                ctrl_valid = 1'b1;
                advance    = 1'b1;
                upc_d      = upc_q + 6'd1;
              end
            end
            SEQ_JUMP: begin
              ctrl_valid = 1'b1;
              advance    = 1'b1;
              upc_d      = rom_word.target;
            end
            default: begin
              ctrl_valid = 1'b1;
              advance    = 1'b1;
              upc_d      = upc_q + 6'd1;
            end
          endcase
        end
      end
      TRAP: begin
        if (trap_ack) begin
          state_d      = IDLE;
          trap_cause_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // the step that hits the limit is still issued; only the routine is cut off
    if (advance) begin
      step_cnt_d = (step_cnt_q == 4'hF) ? step_cnt_q : step_cnt_q + 4'd1;
      if (step_cnt_q == 4'(MAX_STEPS - 1)) begin
        state_d      = TRAP;
        trap_cause_d = 1'b1;
      end
    end

    if (dispatch) begin
      if (illegal_dispatch) begin
        state_d      = TRAP;
        trap_cause_d = 1'b0;
      end else begin
        state_d    = EXEC;
        upc_d      = mapped_address;
        step_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      upc_q        <= '0;
      step_cnt_q   <= '0;
      trap_cause_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      upc_q        <= upc_d;
      step_cnt_q   <= step_cnt_d;
      trap_cause_q <= trap_cause_d;
    end
  end

  assign ctrl_word  = rom_word.ctrl[CTRL_W-1:0];
  assign upc        = upc_q;
  assign trap       = (state_q == TRAP);
  assign trap_cause = trap_cause_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed self-checking bench for micro_sequencer with hand-computed expected values.
// Built with the watchdog test loop at ROM entry 30; follows MICRO_ILLEGAL_TRAP_EN if defined.
module tb_micro_sequencer;

  logic        clk;
  logic        reset;
  logic [5:0]  mapped_address;
  logic        instr_valid;
  logic        instr_ready;
  logic        stall;
  logic        mem_done;
  logic [15:0] ctrl_word;
  logic        ctrl_valid;
  logic [5:0]  upc;
  logic        trap;
  logic        trap_cause;
  logic        trap_ack;

  int errorCount = 0;
  int checkCount = 0;

  micro_sequencer #(
    .CTRL_W       (16),
    .MAX_STEPS    (15),
    .TEST_LOOP_EN (1'b1)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .mapped_address (mapped_address),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .stall          (stall),
    .mem_done       (mem_done),
    .ctrl_word      (ctrl_word),
    .ctrl_valid     (ctrl_valid),
    .upc            (upc),
    .trap           (trap),
    .trap_cause     (trap_cause),
    .trap_ack       (trap_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // inputs change just after the rising edge; outputs are sampled on the following falling edge
  task automatic applyStimulus(input logic v, input logic [5:0] a, input logic s,
                               input logic m, input logic k);
    @(posedge clk);
    #1;
    instr_valid    = v;
    mapped_address = a;
    stall          = s;
    mem_done       = m;
    trap_ack       = k;
    @(negedge clk);
  endtask

  task automatic checkCycle(input string tag, input logic cv, input logic rdy,
                            input logic [5:0] u, input logic [15:0] cw);
    checkOutput({tag, "_ctrl_valid"}, 32'(ctrl_valid), 32'(cv));
    checkOutput({tag, "_instr_ready"}, 32'(instr_ready), 32'(rdy));
    checkOutput({tag, "_upc"}, 32'(upc), 32'(u));
    checkOutput({tag, "_ctrl_word"}, 32'(ctrl_word), 32'(cw));
  endtask

  initial begin
    reset          = 1'b0;
    instr_valid    = 1'b0;
    mapped_address = 6'd0;
    stall          = 1'b0;
    mem_done       = 1'b0;
    trap_ack       = 1'b0;
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    checkCycle("rst", 1'b0, 1'b1, 6'd0, 16'h0000);
    checkOutput("rst_trap", 32'(trap), 32'd0);
    checkOutput("rst_cause", 32'(trap_cause), 32'd0);
    reset = 1'b0;

    // single-word routine; trap_ack while idle must not matter
    applyStimulus(1, 6'd1, 0, 0, 1);
    checkCycle("t1_idle", 1'b0, 1'b1, 6'd0, 16'h0000);
    applyStimulus(0, 6'd0, 0, 0, 0);
    checkCycle("t1_exec", 1'b1, 1'b1, 6'd1, 16'h1001);
    checkOutput("t1_trap", 32'(trap), 32'd0);
    applyStimulus(0, 6'd0, 0, 0, 0);
    checkCycle("t1_back_idle", 1'b0, 1'b1, 6'd1, 16'h1001);

    // back-to-back single-word instructions, no bubble
    applyStimulus(1, 6'd1, 0, 0, 0);
    applyStimulus(1, 6'd2, 0, 0, 0);
    checkCycle("b2b_1", 1'b1, 1'b1, 6'd1, 16'h1001);
    applyStimulus(1, 6'd3, 0, 0, 0);
    checkCycle("b2b_2", 1'b1, 1'b1, 6'd2, 16'h1002);
    applyStimulus(0, 6'd0, 0, 0, 0);
    checkCycle("b2b_3", 1'b1, 1'b1, 6'd3, 16'h1003);
    applyStimulus(0, 6'd0, 0, 0, 0);
    checkCycle("b2b_idle", 1'b0, 1'b1, 6'd3, 16'h1003);

    // load waiting three cycles on memory
    applyStimulus(1, 6'd11, 0, 0, 0);
    applyStimulus(0, 6'd0, 0, 0, 0);
    checkCycle("ld_entry", 1'b1, 1'b0, 6'd11, 16'h2001);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 6'd0, 0, 0, 0);
      checkCycle("ld_wait", 1'b0, 1'b0, 6'd40, 16'h2002);
    end
    applyStimulus(0, 6'd0, 0, 1, 0);
    checkCycle("ld_done", 1'b1, 1'b0, 6'd40, 16'h2002);
    applyStimulus(0, 6'd0, 0, 0, 0);
    checkCycle("ld_end", 1'b1, 1'b1, 6'd41, 16'h2003);
    applyStimulus(0, 6'd0, 0, 0, 0);
    checkCycle("ld_idle", 1'b0, 1'b1, 6'd41, 16'h2003);

    // store: stall overrides mem_done, and a stalled END does not accept
    applyStimulus(1, 6'd12, 0, 0, 0);
    applyStimulus(0, 6'd0, 0, 0, 0);
    checkCycle("st_entry", 1'b1, 1'b0, 6'd12, 16'h3001);
    applyStimulus(0, 6'd0, 1, 1, 0);
    checkCycle("st_stall", 1'b0, 1'b0, 6'd44, 16'h3002);
    applyStimulus(0, 6'd0, 0, 1, 0);
    checkCycle("st_done", 1'b1, 1'b0, 6'd44, 16'h3002);
    applyStimulus(0, 6'd0, 1, 0, 0);
    checkCycle("st_end_stall", 1'b0, 1'b0, 6'd45, 16'h3003);
    applyStimulus(0, 6'd0, 0, 0, 0);
    checkCycle("st_end", 1'b1, 1'b1, 6'd45, 16'h3003);

    // illegal entry address
    applyStimulus(1, 6'd63, 0, 0, 0);
    checkCycle("ill_idle", 1'b0, 1'b1, 6'd45, 16'h3003);
`ifdef MICRO_ILLEGAL_TRAP_EN
    applyStimulus(0, 6'd0, 0, 0, 0);
    checkOutput("ill_trap", 32'(trap), 32'd1);
    checkOutput("ill_cause", 32'(trap_cause), 32'd0);
    checkOutput("ill_ready", 32'(instr_ready), 32'd0);
    checkOutput("ill_cv", 32'(ctrl_valid), 32'd0);
    applyStimulus(0, 6'd0, 0, 0, 0);
    checkOutput("ill_hold", 32'(trap), 32'd1);
    applyStimulus(0, 6'd0, 0, 0, 1);
    checkOutput("ill_ack_cycle", 32'(trap), 32'd1);
    applyStimulus(0, 6'd0, 0, 0, 0);
    checkOutput("ill_cleared", 32'(trap), 32'd0);
    checkOutput("ill_idle_ready", 32'(instr_ready), 32'd1);
`else
    applyStimulus(0, 6'd0, 0, 0, 0);
    checkCycle("ill_nop", 1'b1, 1'b1, 6'd63, 16'h0000);
    checkOutput("ill_no_trap", 32'(trap), 32'd0);
    applyStimulus(0, 6'd0, 0, 0, 0);
    checkCycle("ill_after", 1'b0, 1'b1, 6'd63, 16'h0000);
`endif

    // runaway routine at entry 30: fifteen issued steps, then watchdog trap
    applyStimulus(1, 6'd30, 0, 0, 0);
    checkOutput("wd_accept", 32'(instr_ready), 32'd1);
    for (int i = 0; i < 15; i++) begin
      applyStimulus(0, 6'd0, 0, 0, 0);
      checkOutput("wd_step_cv", 32'(ctrl_valid), 32'd1);
      checkOutput("wd_step_upc", 32'(upc), 32'd30);
      checkOutput("wd_step_trap", 32'(trap), 32'd0);
    end
    applyStimulus(0, 6'd0, 0, 0, 0);
    checkOutput("wd_trap", 32'(trap), 32'd1);
    checkOutput("wd_cause", 32'(trap_cause), 32'd1);
    checkOutput("wd_cv", 32'(ctrl_valid), 32'd0);
    checkOutput("wd_ready", 32'(instr_ready), 32'd0);
    applyStimulus(0, 6'd0, 0, 0, 1);
    checkOutput("wd_ack_cycle", 32'(trap), 32'd1);
    applyStimulus(0, 6'd0, 0, 0, 0);
    checkOutput("wd_cleared", 32'(trap), 32'd0);
    checkOutput("wd_idle_ready", 32'(instr_ready), 32'd1);

    // asynchronous reset in the middle of a load wait
    applyStimulus(1, 6'd11, 0, 0, 0);
    applyStimulus(0, 6'd0, 0, 0, 0);
    applyStimulus(0, 6'd0, 0, 0, 0);
    checkCycle("rr_wait", 1'b0, 1'b0, 6'd40, 16'h2002);
    #2 reset = 1'b1;
    #1;
    checkCycle("rr_reset", 1'b0, 1'b1, 6'd0, 16'h0000);
    checkOutput("rr_trap", 32'(trap), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1, 6'd2, 0, 0, 0);
    applyStimulus(0, 6'd0, 0, 0, 0);
    checkCycle("rr_resume", 1'b1, 1'b1, 6'd2, 16'h1002);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/micro_sequencer.md
# micro_sequencer

Microprogram sequencer that consumes the 6-bit microcode entry address produced by the instruction decode mapper and walks the microcode ROM from that entry. It emits one control word per micro-step until the routine ends, then accepts the next instruction. It sits between decode and the datapath control fan-out, and handles multi-step routines (load/store wait on memory), illegal-instruction trapping and a runaway-routine watchdog.

## Interface
- `CTRL_W`, 16: width of the datapath control field in each microword
- `MAX_STEPS`, 15: maximum micro-steps per routine before watchdog trap
- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `mapped_address`  in  6  microcode entry address from decode (0 = NOP, 63 = illegal)
- `instr_valid`  in  1  `mapped_address` is valid
- `instr_ready`  out  1  sequencer accepts `mapped_address` this cycle
- `stall`  in  1  freeze current micro-step
- `mem_done`  in  1  memory access complete (used by WAIT_MEM steps)
- `ctrl_word`  out  CTRL_W  control field of the current microword
- `ctrl_valid`  out  1  `ctrl_word` is to be applied this cycle
- `upc`  out  6  current micro-PC
- `trap`  out  1  illegal instruction or watchdog trap pending
- `trap_cause`  out  1  0 = illegal, 1 = watchdog
- `trap_ack`  in  1  clears trap

## Operation
- Microword = {ctrl[CTRL_W-1:0], seq[1:0], target[5:0]}. seq: 00 NEXT (upc+1), 01 END, 10 JUMP (upc=target), 11 WAIT_MEM (hold until `mem_done`, then upc+1).
- FSM states: IDLE, EXEC, TRAP.
- IDLE: `instr_ready`=1. On `instr_valid`: address 63 goes to TRAP with cause 0. Any other address sets upc=mapped_address, step_cnt=0 and goes to EXEC.
- EXEC: `ctrl_word`=ROM[upc]. `ctrl_valid` = !stall && !(seq==WAIT_MEM && !mem_done).
- In EXEC with `stall`=1: upc, step_cnt and state hold, and `instr_ready`=0.
- Advance in EXEC when not stalled: NEXT/JUMP/WAIT_MEM(done) update upc and increment step_cnt (4 bits, saturating).
- END in EXEC: `instr_ready`=1. If `instr_valid`, dispatch directly, with no bubble. Otherwise go to IDLE.
- Watchdog: an advance with step_cnt==MAX_STEPS-1 goes to TRAP with cause 1, and the control word of that step is still issued.
- upc wraps 63→0 on NEXT. Address 63 reached inside a routine is treated as a normal microword.
- TRAP: `trap`=1, `ctrl_valid`=0, `instr_ready`=0. `trap_ack` returns the FSM to IDLE the next cycle.
- ROM contents:
  - Entry 11 (load): JUMP→40; 40 WAIT_MEM; 41 END.
  - Entry 12 (store): JUMP→44; 44 WAIT_MEM; 45 END.
  - Entries 0–10 and 13–26: single END word.
  - All other addresses: END with ctrl=0.

## Timing
- Reset values: state IDLE, upc=0, step_cnt=0, `ctrl_word`=ROM[0], `ctrl_valid`=0, `instr_ready`=1, `trap`=0, `trap_cause`=0.
- Accept in cycle N → first `ctrl_valid` in cycle N+1.
- A single-word routine occupies 1 cycle. Back-to-back single-word instructions give one control word per cycle.
- Load with `mem_done` in the same cycle as WAIT_MEM: 3 control cycles (11, 40, 41).
- `stall` and `mem_done` in the same cycle: stall wins, and `mem_done` is ignored for that cycle.
- `trap_ack` outside TRAP: ignored.
- Reset asserted mid-routine: all registers return to reset values immediately.

## Configuration
- `MICRO_ILLEGAL_TRAP_EN` defined: address 63 at dispatch enters TRAP with cause 0, as described above.
- Not defined: address 63 at dispatch executes ROM[63] (END, ctrl=0) as a one-cycle NOP, and `trap` is driven only by the watchdog.

## Structure
- Shared package `micro_pkg`:
  - seq encodings (SEQ_NEXT/END/JUMP/WAIT_MEM)
  - FSM state enum
  - microword struct/width constant
  - entry constants (ADDR_NOP=0, ADDR_LOAD=11, ADDR_STORE=12, ADDR_ILLEGAL=63)
- Sub-module `micro_rom`: 64-entry combinational ROM indexed by upc, returning the microword.

## Test plan
- Reset, then `mapped_address`=1 with `instr_valid` → `ctrl_valid`=1 for one cycle with upc=1, `instr_ready`=1 in that same cycle.
- Addresses 1,2,3 valid on consecutive cycles → upc 1,2,3 on consecutive cycles, no bubble.
- Address 11 with `mem_done` low for 3 cycles at upc=40 → upc sequence 11,40,40,40,40,41. `ctrl_valid` is 0 during the three waiting cycles, and `instr_ready`=1 only at 41.
- Address 63 with the macro defined → `trap`=1, `trap_cause`=0, `instr_ready`=0. `trap_ack` returns the FSM to IDLE next cycle. Without the macro → one NOP cycle at upc=63 and no trap.
- Test ROM built with a JUMP-to-self loop at entry 30 → `trap`=1, `trap_cause`=1 after 15 steps.
- `reset` asserted while upc=40 during WAIT_MEM → upc=0, `ctrl_valid`=0, `instr_ready`=1 immediately.
